toggle_hs_rx: RTL and testbench

Receiver end of the team's toggle (T-flip-flop style) request/acknowledge handshake. The sender flips req_tgl once per transfer, with req_data held stable. This block detects each flip and captures the data. It presents the data on a valid/ready port, then flips ack_tgl back to the sender once the downstream side has consumed the word. It also keeps a saturating event count and a sticky protocol-error flag.

---
 rtl/toggle_hs_rx_pkg.sv | 15 +
 rtl/toggle_hs_rx_if.sv | 28 ++
 rtl/toggle_hs_rx_edge_det.sv | 30 +++
 rtl/toggle_hs_rx.sv | 77 +++++++
 tb/tb_toggle_hs_rx.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/toggle_hs_rx_pkg.sv
// Shared types and defaults for the toggle-handshake receiver.
package toggle_hs_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

  // All-ones value of the default-width event counter
  localparam logic [CNT_W_DEF-1:0] CNT_MAX_DEF = '1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/toggle_hs_rx_if.sv
// Toggle request/acknowledge link plus downstream valid/ready port and status.
interface toggle_hs_rx_if
  import toggle_hs_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) ();

  logic              req_tgl;
  logic [DATA_W-1:0] req_data;
  logic              ack_tgl;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [CNT_W-1:0]  evt_cnt;
  logic              err_overrun;

  modport master (
    output req_tgl, req_data, out_ready,
    input  ack_tgl, out_valid, out_data, evt_cnt, err_overrun
  );

  modport slave (
    input  req_tgl, req_data, out_ready,
    output ack_tgl, out_valid, out_data, evt_cnt, err_overrun
  );

endinterface

// File: rtl/toggle_hs_rx_edge_det.sv
// Request-toggle edge detector; TOGGLE_HS_RX_SYNC_EN adds a 2-flop synchronizer.
module toggle_edge_det (
  input  logic clk,
  input  logic req_tgl_i,
  output logic tgl_det_o
);

  logic req_s;
  logic req_prev_q;

`ifdef TOGGLE_HS_RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    sync_q <= {sync_q[0], req_tgl_i};
  end

  assign req_s = sync_q[1];
`else
  assign req_s = req_tgl_i;
`endif

  // Loads through reset too, so the sender's idle level never looks like a flip
  always_ff @(posedge clk) begin
    req_prev_q <= req_s;
  end

  assign tgl_det_o = req_s ^ req_prev_q;

endmodule

// File: rtl/toggle_hs_rx.sv
// Toggle-handshake receiver: captures each request flip, presents it on valid/ready,
// acknowledges on consumption. Optional input sync: define TOGGLE_HS_RX_SYNC_EN.
module toggle_hs_rx
  import toggle_hs_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  toggle_hs_rx_if.slave   hs
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic              tgl_det;
  state_t            state_q;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              ack_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              err_q;

  toggle_edge_det u_edge_det (
    .clk       (clk),
    .req_tgl_i (hs.req_tgl),
    .tgl_det_o (tgl_det)
  );

  assign cnt_d = sat_inc(cnt_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tgl_det) begin
            data_q  <= hs.req_data;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          // A flip while a word is pending is dropped, only flagged
          if (tgl_det) begin
            err_q <= 1'b1;
          end
          if (hs.out_ready) begin
            valid_q <= 1'b0;
            ack_q   <= ~ack_q;
            cnt_q   <= cnt_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hs.ack_tgl     = ack_q;
  assign hs.out_valid   = valid_q;
  assign hs.out_data    = data_q;
  assign hs.evt_cnt     = cnt_q;
  assign hs.err_overrun = err_q;

endmodule

// File: tb/tb_toggle_hs_rx.sv
// Randomized bench for toggle_hs_rx against a transaction-level reference model.
module tb_toggle_hs_rx;
  import toggle_hs_pkg::*;

  localparam int DW  = 8;
  localparam int CW  = 8;
  localparam int CW2 = 2;
`ifdef TOGGLE_HS_RX_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  toggle_hs_rx_if #(.DATA_W(DW), .CNT_W(CW))  hs ();
  toggle_hs_rx_if #(.DATA_W(DW), .CNT_W(CW2)) hs2 ();

  toggle_hs_rx #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .hs    (hs.slave)
  );

  toggle_hs_rx #(.DATA_W(DW), .CNT_W(CW2)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .hs    (hs2.slave)
  );

  logic rand_ready = 1'b0;
  logic ready_man  = 1'b0;
  logic rnd_bit    = 1'b0;

  always @(negedge clk) rnd_bit = 1'($urandom_range(0, 1));

  assign hs.out_ready  = rand_ready ? rnd_bit : ready_man;
  assign hs2.req_tgl   = hs.req_tgl;
  assign hs2.req_data  = hs.req_data;
  assign hs2.out_ready = hs.out_ready;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one pending word at most, acks = consumed count mod 2
  logic       m_pend = 1'b0;
  logic       m_err  = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         m_n    = 0;
  logic       m_last = 1'b0;
  logic       h0 = 1'b0, h1 = 1'b0;
  logic       chk_en = 1'b0;

  always @(posedge clk) begin
    logic seen;
    logic flip;
    seen = (LAT == 3) ? h1 : hs.req_tgl;
    h1 = h0;
    h0 = hs.req_tgl;
    if (!reset) begin
      m_pend = 1'b0;
      m_err  = 1'b0;
      m_data = 8'h00;
      m_n    = 0;
    end else begin
      flip = (seen != m_last);
      if (m_pend) begin
        if (flip) m_err = 1'b1;
        if (hs.out_ready) begin
          m_pend = 1'b0;
          m_n++;
        end
      end else if (flip) begin
        m_pend = 1'b1;
        m_data = hs.req_data;
      end
    end
    m_last = seen;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_out_valid", 32'(hs.out_valid), 32'(m_pend));
      chk("m_out_data", 32'(hs.out_data), 32'(m_data));
      chk("m_ack_tgl", 32'(hs.ack_tgl), 32'(m_n % 2));
      chk("m_evt_cnt", 32'(hs.evt_cnt), 32'((m_n > 255) ? 255 : m_n));
      chk("m_evt_cnt_w2", 32'(hs2.evt_cnt), 32'((m_n > 3) ? 3 : m_n));
      chk("m_err_overrun", 32'(hs.err_overrun), 32'(m_err));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic lvl);
    @(negedge clk);
    reset = 1'b0;
    hs.req_tgl = lvl;
    tick(4);
    reset = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input int gap);
    tick(gap);
    hs.req_data = d;
    hs.req_tgl  = ~hs.req_tgl;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (hs.ack_tgl == hs.req_tgl) break;
    end
    chk("xfer_ack", 32'(hs.ack_tgl), 32'(hs.req_tgl));
  endtask

  int sat_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    reset       = 1'b0;
    hs.req_tgl  = 1'b1;
    hs.req_data = 8'h00;
    tick(4);
    chk_en = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(3);
    chk("rst_valid", 32'(hs.out_valid), 32'd0);
    chk("rst_cnt", 32'(hs.evt_cnt), 32'd0);
    chk("rst_ack", 32'(hs.ack_tgl), 32'd0);
    chk("rst_err", 32'(hs.err_overrun), 32'd0);

    do_reset(1'b0);
    tick(3);

    // Single transfer with latency check
    ready_man   = 1'b1;
    hs.req_data = 8'hA5;
    hs.req_tgl  = 1'b1;
    for (int i = 1; i < LAT; i++) begin
      tick(1);
      chk("lat_early_valid", 32'(hs.out_valid), 32'd0);
    end
    tick(1);
    chk("single_valid", 32'(hs.out_valid), 32'd1);
    chk("single_data", 32'(hs.out_data), 32'hA5);
    chk("single_ack_pre", 32'(hs.ack_tgl), 32'd0);
    tick(1);
    chk("single_ack", 32'(hs.ack_tgl), 32'd1);
    chk("single_cnt", 32'(hs.evt_cnt), 32'd1);
    chk("single_valid_drop", 32'(hs.out_valid), 32'd0);

    // Backpressure
    ready_man   = 1'b0;
    hs.req_data = 8'h3C;
    hs.req_tgl  = 1'b0;
    tick(LAT);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(hs.out_valid), 32'd1);
      chk("bp_data", 32'(hs.out_data), 32'h3C);
      chk("bp_ack_hold", 32'(hs.ack_tgl), 32'd1);
      tick(1);
    end
    ready_man = 1'b1;
    tick(1);
    chk("bp_ack", 32'(hs.ack_tgl), 32'd0);
    chk("bp_cnt", 32'(hs.evt_cnt), 32'd2);
    chk("bp_valid_drop", 32'(hs.out_valid), 32'd0);

    // Overrun
    ready_man   = 1'b0;
    hs.req_data = 8'h11;
    hs.req_tgl  = 1'b1;
    tick(LAT);
    chk("ovr_first_valid", 32'(hs.out_valid), 32'd1);
    hs.req_data = 8'h22;
    hs.req_tgl  = 1'b0;
    tick(LAT + 1);
    chk("ovr_err", 32'(hs.err_overrun), 32'd1);
    chk("ovr_data_kept", 32'(hs.out_data), 32'h11);
    ready_man = 1'b1;
    tick(1);
    chk("ovr_cnt", 32'(hs.evt_cnt), 32'd3);
    chk("ovr_valid_drop", 32'(hs.out_valid), 32'd0);
    tick(LAT + 3);
    chk("ovr_no_redetect", 32'(hs.out_valid), 32'd0);
    chk("ovr_err_sticky", 32'(hs.err_overrun), 32'd1);
    chk("ovr_cnt_hold", 32'(hs.evt_cnt), 32'd3);
    ready_man = 1'b0;

    do_reset(1'b0);
    tick(1);
    chk("rst2_err", 32'(hs.err_overrun), 32'd0);
    chk("rst2_cnt", 32'(hs.evt_cnt), 32'd0);

    // Saturation on the narrow counter
    ready_man = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(8'($urandom), 1);
      chk("sat_cnt_w2", 32'(hs2.evt_cnt), 32'(sat_exp[i]));
    end

    // Random traffic with random backpressure and sender gaps
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(8'($urandom), $urandom_range(0, 3));
    end
    rand_ready = 1'b0;
    ready_man  = 1'b0;
    tick(2);

    // Reset while a word is pending
    hs.req_data = 8'h5A;
    hs.req_tgl  = ~hs.req_tgl;
    tick(LAT);
    chk("mid_valid", 32'(hs.out_valid), 32'd1);
    reset      = 1'b0;
    hs.req_tgl = 1'b0;
    tick(1);
    chk("mid_rst_valid", 32'(hs.out_valid), 32'd0);
    chk("mid_rst_ack", 32'(hs.ack_tgl), 32'd0);
    chk("mid_rst_cnt", 32'(hs.evt_cnt), 32'd0);
    chk("mid_rst_data", 32'(hs.out_data), 32'd0);
    tick(3);
    reset = 1'b1;
    tick(4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
